// File: rtl/mcb_port_responder.sv
// mcb_port_responder: block-RAM backed responder for the MCB p0 user port
// (cmd / wr / rd FIFO protocol), single clock domain.
// Optional build macro: MCB_RESP_INIT_PATTERN_EN -- fills memory with
// {16'hA5A5, word_index[15:0]} during calibration.
module mcb_port_responder #(
  parameter int unsigned ADDR_WORDS_LOG2 = 10,
  parameter int unsigned CMD_DEPTH       = 4,
  parameter int unsigned DATA_DEPTH      = 64,
  parameter int unsigned CALIB_CYCLES    = 16,
  parameter int unsigned ACCESS_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_bl,
  input  logic [29:0] cmd_byte_addr,
  output logic        cmd_empty,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [3:0]  wr_mask,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic [6:0]  wr_count,
  output logic        wr_underrun,
  output logic        wr_error,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_full,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        rd_overflow,
  output logic        rd_error
);

  localparam int unsigned AW        = ADDR_WORDS_LOG2;
  localparam int unsigned MEM_WORDS = 1 << AW;
  localparam int unsigned CPW       = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned DPW       = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
`ifdef MCB_RESP_INIT_PATTERN_EN
  localparam int unsigned CALIB_LEN = (CALIB_CYCLES > MEM_WORDS) ? CALIB_CYCLES : MEM_WORDS;
`else
  localparam int unsigned CALIB_LEN = CALIB_CYCLES;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_READ_WAIT,
    S_READ
  } state_t;

  typedef struct packed {
    logic [2:0]    instr;
    logic [5:0]    bl;
    logic [AW-1:0] addr;
  } cmd_t;

  // ---------------------------------------------------------------- state
  state_t         state;
  cmd_t           cur;
  logic [AW-1:0]  eng_addr;
  logic [6:0]     beat_cnt;
  logic [15:0]    wait_cnt;

  logic [31:0]    calib_cnt;
  logic           calib_done_q;

  cmd_t           cmd_mem [CMD_DEPTH];
  logic [CPW-1:0] cmd_wp, cmd_rp;
  logic [CPW:0]   cmd_cnt;

  logic [35:0]    wr_mem [DATA_DEPTH];
  logic [DPW-1:0] wr_wp, wr_rp;
  logic [6:0]     wr_cnt;

  logic [31:0]    rd_mem [DATA_DEPTH];
  logic [DPW-1:0] rd_wp, rd_rp;
  logic [6:0]     rd_cnt;
  logic [31:0]    rd_last;

  logic [31:0]    mem [MEM_WORDS];

  logic wr_underrun_q, rd_overflow_q, wr_error_q, rd_error_q;

  // ---------------------------------------------------------------- flags
  logic cmd_fifo_full, wr_full_i, wr_empty_i, rd_full_i, rd_empty_i;
  logic cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop;
  logic underrun_now, overflow_now;
  logic [35:0] wr_head;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{cmd_byte_addr[29:AW+2], cmd_byte_addr[1:0]};

  assign cmd_fifo_full = (cmd_cnt == (CPW+1)'(CMD_DEPTH));
  assign wr_full_i     = (wr_cnt == 7'(DATA_DEPTH));
  assign wr_empty_i    = (wr_cnt == 7'd0);
  assign rd_full_i     = (rd_cnt == 7'(DATA_DEPTH));
  assign rd_empty_i    = (rd_cnt == 7'd0);

  assign cmd_push = cmd_en && calib_done_q && !cmd_fifo_full;
  assign cmd_pop  = (state == S_IDLE) && (cmd_cnt != '0);
  assign wr_push  = wr_en && !wr_full_i;
  assign wr_pop   = (state == S_WRITE) && !wr_empty_i;
  assign rd_push  = (state == S_READ) && !rd_full_i;
  assign rd_pop   = rd_en && !rd_empty_i;

  assign underrun_now = (state == S_WRITE) && wr_empty_i;
  assign overflow_now = (state == S_READ) && rd_full_i;
  assign wr_head      = wr_mem[wr_rp];

  assign calib_done  = calib_done_q;
  assign cmd_empty   = (cmd_cnt == '0);
  assign cmd_full    = !calib_done_q || cmd_fifo_full;
  assign wr_full     = wr_full_i;
  assign wr_empty    = wr_empty_i;
  assign wr_count    = wr_cnt;
  assign wr_underrun = wr_underrun_q;
  assign wr_error    = wr_error_q;
  assign rd_full     = rd_full_i;
  assign rd_empty    = rd_empty_i;
  assign rd_count    = rd_cnt;
  assign rd_overflow = rd_overflow_q;
  assign rd_error    = rd_error_q;
  // Empty FIFO presents the last popped word (0 after reset) so rd_data holds.
  assign rd_data     = rd_empty_i ? rd_last : rd_mem[rd_rp];

  function automatic logic [CPW-1:0] cnext(input logic [CPW-1:0] p);
    return (p == CPW'(CMD_DEPTH - 1)) ? '0 : p + CPW'(1);
  endfunction

  function automatic logic [DPW-1:0] dnext(input logic [DPW-1:0] p);
    return (p == DPW'(DATA_DEPTH - 1)) ? '0 : p + DPW'(1);
  endfunction

  // Calibration counter; calib_done rises after CALIB_LEN clocks out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib_cnt    <= '0;
      calib_done_q <= 1'b0;
    end else if (!calib_done_q) begin
      calib_cnt <= calib_cnt + 32'd1;
      if (calib_cnt + 32'd1 >= CALIB_LEN) calib_done_q <= 1'b1;
    end
  end

  // Command FIFO storage.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= '{instr: cmd_instr, bl: cmd_bl,
                                       addr: cmd_byte_addr[AW+1:2]};
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) cmd_wp <= cnext(cmd_wp);
      if (cmd_pop)  cmd_rp <= cnext(cmd_rp);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + 1'b1;
        2'b01:   cmd_cnt <= cmd_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Write FIFO storage: {mask, data}.
  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wp] <= {wr_mask, wr_data};
  end

  // Write FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_wp  <= '0;
      wr_rp  <= '0;
      wr_cnt <= '0;
    end else begin
      if (wr_push) wr_wp <= dnext(wr_wp);
      if (wr_pop)  wr_rp <= dnext(wr_rp);
      case ({wr_push, wr_pop})
        2'b10:   wr_cnt <= wr_cnt + 7'd1;
        2'b01:   wr_cnt <= wr_cnt - 7'd1;
        default: ;
      endcase
    end
  end

  // Read FIFO storage, filled from memory by the engine.
  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wp] <= mem[eng_addr];
  end

  // Read FIFO pointers, occupancy and held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wp   <= '0;
      rd_rp   <= '0;
      rd_cnt  <= '0;
      rd_last <= '0;
    end else begin
      if (rd_push) rd_wp <= dnext(rd_wp);
      if (rd_pop) begin
        rd_rp   <= dnext(rd_rp);
        rd_last <= rd_mem[rd_rp];
      end
      case ({rd_push, rd_pop})
        2'b10:   rd_cnt <= rd_cnt + 7'd1;
        2'b01:   rd_cnt <= rd_cnt - 7'd1;
        default: ;
      endcase
    end
  end

  // Memory write port: engine write beats, or the init fill during calibration.
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [31:0]   mem_wd;
  logic [3:0]    mem_wbe;

  always_comb begin
    mem_we  = wr_pop;
    mem_wa  = eng_addr;
    mem_wd  = wr_head[31:0];
    mem_wbe = ~wr_head[35:32];
`ifdef MCB_RESP_INIT_PATTERN_EN
    if (!rst && !calib_done_q && (calib_cnt < MEM_WORDS)) begin
      mem_we  = 1'b1;
      mem_wa  = calib_cnt[AW-1:0];
      mem_wd  = {16'hA5A5, calib_cnt[15:0]};
      mem_wbe = '1;
    end
`endif
  end

  // Byte-lane masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_wbe[b]) mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  // Engine FSM: pop command, decode, run write or read burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cur      <= '0;
      eng_addr <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            cur   <= cmd_mem[cmd_rp];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          eng_addr <= cur.addr;
          beat_cnt <= '0;
          wait_cnt <= '0;
          case (cur.instr)
            3'b000, 3'b010: state <= S_WRITE;
            3'b001, 3'b011: state <= (ACCESS_LATENCY == 0) ? S_READ : S_READ_WAIT;
            default:        state <= S_IDLE;
          endcase
        end
        S_WRITE, S_READ: begin
          eng_addr <= eng_addr + AW'(1);
          beat_cnt <= beat_cnt + 7'd1;
          if (beat_cnt == {1'b0, cur.bl}) state <= S_IDLE;
        end
        S_READ_WAIT: begin
          wait_cnt <= wait_cnt + 16'd1;
          if (wait_cnt == 16'(ACCESS_LATENCY - 1)) state <= S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Underrun / overflow pulses and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_underrun_q <= 1'b0;
      rd_overflow_q <= 1'b0;
      wr_error_q    <= 1'b0;
      rd_error_q    <= 1'b0;
    end else begin
      wr_underrun_q <= underrun_now;
      rd_overflow_q <= overflow_now;
      if ((wr_en && wr_full_i) || underrun_now)  wr_error_q <= 1'b1;
      if ((rd_en && rd_empty_i) || overflow_now) rd_error_q <= 1'b1;
    end
  end

endmodule
